// File: rtl/pomo_pkg.sv
// Shared constants for the pomodoro countdown engine.
// Phase codes, FSM state encoding and a BCD helper for reload values.
package pomo_pkg;

    localparam logic [1:0] PH_WORK  = 2'd0;
    localparam logic [1:0] PH_BREAK = 2'd1;
    localparam logic [1:0] PH_LONG  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // 0..99 -> two packed BCD digits
    function automatic logic [7:0] to_bcd2(input int v);
        to_bcd2 = {4'(v / 10), 4'(v % 10)};
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load and borrow out.
// Ports: clk, dec_en, load, load_val[3:0] -> digit[3:0], borrow_out.
module bcd_down_digit #(
    parameter int MAXVAL = 9
) (
    input  logic       clk,
    input  logic       dec_en,
    input  logic       load,
    input  logic [3:0] load_val,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] q;

    // load has priority so a reload never mixes with a decrement
    always_ff @(posedge clk) begin
        if (load) begin
            q <= load_val;
        end else if (dec_en) begin
            q <= (q == 4'd0) ? 4'(MAXVAL) : q - 4'd1;
        end
    end

    assign digit      = q;
    assign borrow_out = dec_en && (q == 4'd0);

endmodule

// File: rtl/pomo_countdown.sv
// Pomodoro MM:SS BCD countdown with run/pause/clear/skip and phase sequencing.
// Ports: clk, rst (sync, active-high), start_pause, clr, skip pulses in;
//   bcd[15:0] MM:SS digits, phase[1:0], running, done_pulse, session_cnt[1:0].
// Define POMO_LONG_BREAK_EN to make every fourth break a long break.
module pomo_countdown
    import pomo_pkg::*;
#(
    parameter int TICK_DIV       = 100000000,
    parameter int WORK_MIN       = 25,
    parameter int BREAK_MIN      = 5,
    parameter int LONG_BREAK_MIN = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_pause,
    input  logic        clr,
    input  logic        skip,
    output logic [15:0] bcd,
    output logic [1:0]  phase,
    output logic        running,
    output logic        done_pulse,
    output logic [1:0]  session_cnt
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    localparam logic [15:0] WORK_LD = {to_bcd2(WORK_MIN), 8'h00};
    localparam logic [15:0] BRK_LD  = {to_bcd2(BREAK_MIN), 8'h00};
    localparam logic [15:0] LONG_LD = {to_bcd2(LONG_BREAK_MIN), 8'h00};

    state_t          state;
    state_t          state_nx;
    logic [PW-1:0]   presc;
    logic            tick;
    logic            tick_eff;
    logic            zero;
    logic            expire;
    logic            dec;
    logic            adv;
    logic            long_sel;
    logic [1:0]      ph_nx;
    logic [15:0]     adv_ld;
    logic            load;
    logic [15:0]     load_val;
    logic            b0;
    logic            b1;
    logic            b2;
    logic            unused_borrow;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ST_IDLE;
        end else if (start_pause) begin
            unique case (state)
                ST_IDLE:  state_nx = ST_RUN;
                ST_RUN:   state_nx = ST_PAUSE;
                ST_PAUSE: state_nx = ST_RUN;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        running = (state == ST_RUN);
    end

    // ------------- tick / events -------------
    // Any higher-priority pulse swallows the tick; a start_pause in RUN
    // always leaves RUN, so it discards the tick too.
    assign tick     = (state == ST_RUN) && (presc == LAST);
    assign tick_eff = tick && !clr && !skip && !start_pause;
    assign zero     = (bcd == 16'h0000);
    assign expire   = tick_eff && zero;
    assign dec      = tick_eff && !zero;
    assign adv      = !clr && (skip || expire);

`ifdef POMO_LONG_BREAK_EN
    // the completion that wraps session_cnt 3 -> 0 earns the long break
    assign long_sel = (session_cnt == 2'd3);
`else
    assign long_sel = 1'b0;
`endif

    always_comb begin
        ph_nx  = PH_WORK;
        adv_ld = WORK_LD;
        if (phase == PH_WORK) begin
            if (long_sel) begin
                ph_nx  = PH_LONG;
                adv_ld = LONG_LD;
            end else begin
                ph_nx  = PH_BREAK;
                adv_ld = BRK_LD;
            end
        end
    end

    assign load     = rst || clr || adv;
    assign load_val = (rst || clr) ? WORK_LD : adv_ld;

    // ------------- phase / session / prescaler -------------
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            presc       <= '0;
            phase       <= PH_WORK;
            session_cnt <= 2'd0;
            done_pulse  <= 1'b0;
        end else begin
            done_pulse <= expire;
            if (adv) begin
                phase <= ph_nx;
                presc <= '0;
                if (phase == PH_WORK) begin
                    session_cnt <= session_cnt + 2'd1;
                end
            end else if ((state == ST_RUN) && !start_pause) begin
                presc <= tick ? '0 : presc + 1'b1;
            end
        end
    end

    // ------------- digit chain -------------
    bcd_down_digit #(.MAXVAL(9)) u_s1 (
        .clk        (clk),
        .dec_en     (dec),
        .load       (load),
        .load_val   (load_val[3:0]),
        .digit      (bcd[3:0]),
        .borrow_out (b0)
    );

    bcd_down_digit #(.MAXVAL(5)) u_s10 (
        .clk        (clk),
        .dec_en     (b0),
        .load       (load),
        .load_val   (load_val[7:4]),
        .digit      (bcd[7:4]),
        .borrow_out (b1)
    );

    bcd_down_digit #(.MAXVAL(9)) u_m1 (
        .clk        (clk),
        .dec_en     (b1),
        .load       (load),
        .load_val   (load_val[11:8]),
        .digit      (bcd[11:8]),
        .borrow_out (b2)
    );

    // never borrows: decrement only happens while bcd is non-zero
    bcd_down_digit #(.MAXVAL(9)) u_m10 (
        .clk        (clk),
        .dec_en     (b2),
        .load       (load),
        .load_val   (load_val[15:12]),
        .digit      (bcd[15:12]),
        .borrow_out (unused_borrow)
    );

endmodule
